// File: rtl/redma_pkg.sv
// Shared AXI constants and FSM state type for the REDMA read engine.
package redma_pkg;

  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam int unsigned BOUNDARY_4K = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/redma_burst_split.sv
// Combinational burst sizing: min(remaining beats, MAX_BURST, beats left before the next 4 KB page).
module redma_burst_split
  import redma_pkg::*;
#(
  parameter int LEN_WIDTH   = 32,
  parameter int BEAT_BYTES  = 64,
  parameter int MAX_BURST   = 64,
  parameter int BEATS_WIDTH = $clog2(MAX_BURST) + 1
) (
  input  logic [11:0]            addr,
  input  logic [LEN_WIDTH-1:0]   rem_beats,
  output logic [BEATS_WIDTH-1:0] beats
);

  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

  logic [12:0]          bytes_to_4k;
  logic [LEN_WIDTH-1:0] beats_to_4k;
  logic [LEN_WIDTH-1:0] cand;

  // NOTE: every variable gets a value before any conditional override, so no latch is inferred.
  always_comb begin
    bytes_to_4k = 13'(BOUNDARY_4K) - {1'b0, addr};
    beats_to_4k = LEN_WIDTH'(bytes_to_4k >> BEAT_SHIFT);
    cand        = rem_beats;
    if (cand > LEN_WIDTH'(MAX_BURST)) cand = LEN_WIDTH'(MAX_BURST);
    if (cand > beats_to_4k)           cand = beats_to_4k;
    beats       = BEATS_WIDTH'(cand);
  end

endmodule

// File: rtl/redma_rd_engine.sv
// AXI4 read engine: splits a byte-length transfer into 4 KB-safe INCR bursts and streams R beats into a FIFO.
module redma_rd_engine
  import redma_pkg::*;
#(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int MAX_BURST       = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LEN_WIDTH       = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [LEN_WIDTH-1:0]  byte_len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic                  fifo_full,
  output logic                  fifo_write,
  output logic [DATA_WIDTH-1:0] fifo_data
);

  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int BW         = $clog2(MAX_BURST) + 1;
  localparam int OW         = $clog2(MAX_OUTSTANDING + 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  issue_left;
  logic [LEN_WIDTH-1:0]  recv_left;
  logic [OW-1:0]         outstanding;
  logic [OW-1:0]         out_next;
  logic                  arvalid_q;
  logic                  done_q;
  logic [BW-1:0]         beats;
  logic [LEN_WIDTH-1:0]  issue_left_next;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  last_hs;
  logic                  can_issue;

  redma_burst_split #(
    .LEN_WIDTH  (LEN_WIDTH),
    .BEAT_BYTES (BEAT_BYTES),
    .MAX_BURST  (MAX_BURST),
    .BEATS_WIDTH(BW)
  ) u_split (
    .addr     (addr_q[11:0]),
    .rem_beats(issue_left),
    .beats    (beats)
  );

  assign busy       = (state != ST_IDLE);
  assign done       = done_q;
  assign araddr     = addr_q;
  assign arlen      = 8'(beats - BW'(1));
  assign arsize     = 3'(BEAT_SHIFT);
  assign arburst    = BURST_INCR;
  assign arvalid    = arvalid_q;
  // R is only accepted while a transfer is live, so stale responses after reset never reach the FIFO.
  assign rready     = busy && !fifo_full;
  assign fifo_write = rvalid && rready;
  assign fifo_data  = rdata;

  assign ar_hs           = arvalid_q && arready;
  assign r_hs            = rvalid && rready;
  assign last_hs         = r_hs && rlast && (outstanding != '0);
  assign issue_left_next = issue_left - LEN_WIDTH'(beats);
  assign can_issue       = (out_next < OW'(MAX_OUTSTANDING));

  always_comb begin
    out_next = outstanding;
    if (ar_hs && !last_hs)      out_next = outstanding + OW'(1);
    else if (!ar_hs && last_hs) out_next = outstanding - OW'(1);
  end

  // NOTE: sequential state uses <= so every register samples the same pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      issue_left  <= '0;
      recv_left   <= '0;
      outstanding <= '0;
      arvalid_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      outstanding <= out_next;
      if (r_hs && recv_left != '0) recv_left <= recv_left - LEN_WIDTH'(1);

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (byte_len == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q      <= src_addr;
              issue_left  <= byte_len >> BEAT_SHIFT;
              recv_left   <= byte_len >> BEAT_SHIFT;
              outstanding <= '0;
              arvalid_q   <= 1'b1;
              state       <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (ar_hs) begin
            addr_q     <= addr_q + (ADDR_WIDTH'(beats) << BEAT_SHIFT);
            issue_left <= issue_left_next;
            if (issue_left_next == '0) begin
              arvalid_q <= 1'b0;
              state     <= ST_DRAIN;
            end else begin
              arvalid_q <= can_issue;
            end
          end else if (!arvalid_q) begin
            arvalid_q <= can_issue;
          end
        end
        ST_DRAIN: begin
          // Completion follows the beat counter; rlast only retires outstanding bursts.
          if (r_hs && recv_left == LEN_WIDTH'(1)) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
